// File: rtl/pipeline_chain.sv
// Elastic register pipeline with combinational bubble collapse, partial flush,
// live occupancy count and a retired-transfer counter.
module pipeline_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int SW    = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       flush,
  input  logic [SW-1:0]              flush_stage,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [31:0]                retired
);

  localparam int OW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] v_next;
  logic [DEPTH-1:0] v_shift;
  logic [DEPTH:0]   r;
  logic [WIDTH-1:0] d [DEPTH];
  logic [OW-1:0]    occ_next;
  int unsigned      fs;

  // Readiness ripples from the output back to stage 0; any bubble opens every younger stage.
  always_comb begin
    logic carry;
    r        = '0;
    carry    = out_ready;
    r[DEPTH] = out_ready;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      carry          = !v[DEPTH-1-i] || carry;
      r[DEPTH-1-i]   = carry;
    end
  end

  assign in_ready  = r[0];
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

  always_comb begin
    v_shift  = {v[DEPTH-2:0], in_valid};
    fs       = (32'(flush_stage) > 32'(DEPTH-1)) ? 32'(DEPTH-1) : 32'(flush_stage);
    v_next   = v;
    occ_next = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (r[k]) v_next[k] = v_shift[k];
      // The payload leaving the oldest flushed stage is dropped rather than handed on.
      if (flush && r[k] && (k == fs + 1)) v_next[k] = 1'b0;
      if (flush && (k <= fs)) v_next[k] = 1'b0;
      occ_next = occ_next + OW'(v_next[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v         <= '0;
      occupancy <= '0;
      retired   <= '0;
    end else begin
      v         <= v_next;
      occupancy <= occ_next;
      if (out_valid && out_ready) retired <= retired + 32'd1;
    end
  end

  // Payload registers carry no reset; their contents only matter when the valid bit is set.
  always_ff @(posedge clk) begin
    if (r[0]) d[0] <= in_data;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      if (r[k]) d[k] <= d[k-1];
    end
  end

endmodule

// File: tb/tb_pipeline_chain.sv
// Scoreboarded bench for pipeline_chain: directed scenarios then random traffic,
// with a slot-level reference model and an in-order payload queue.
module tb_pipeline_chain;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int SW    = $clog2(DEPTH);
  localparam int OW    = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic              flush;
  logic [SW-1:0]     flush_stage;
  logic [OW-1:0]     occupancy;
  logic [31:0]       retired;

  pipeline_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SW(SW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .flush_stage(flush_stage),
    .occupancy(occupancy), .retired(retired)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  logic [WIDTH-1:0] exp_q[$];
  bit               m_v [DEPTH];
  logic [WIDTH-1:0] m_d [DEPTH];
  logic [31:0]      m_ret = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_occ();
    int n = 0;
    for (int k = 0; k < DEPTH; k++) n += int'(m_v[k]);
    return n;
  endfunction

  // A stage may move if the consumer is ready or there is a hole anywhere at or beyond it.
  function automatic bit m_ready(input int k, input bit ordy);
    if (ordy) return 1'b1;
    for (int j = k; j < DEPTH; j++) if (!m_v[j]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step(input bit iv, input logic [WIDTH-1:0] id, input bit ordy,
                            input bit fl, input int fsel, input bit rst);
    bit               rdy [DEPTH];
    bit               nv  [DEPTH];
    logic [WIDTH-1:0] nd  [DEPTH];
    bit               oxfer;
    int               fs;
    int               kill;
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) m_v[k] = 1'b0;
      exp_q.delete();
      m_ret = '0;
      return;
    end
    for (int k = 0; k < DEPTH; k++) rdy[k] = m_ready(k, ordy);
    oxfer = m_v[DEPTH-1] && ordy;
    fs    = (fsel > DEPTH-1) ? DEPTH-1 : fsel;
    kill  = 0;
    if (fl)
      for (int k = 0; k <= fs; k++)
        if (m_v[k] && !(k == DEPTH-1 && oxfer)) kill++;
    repeat (kill) void'(exp_q.pop_back());
    if (iv && rdy[0] && !fl) exp_q.push_back(id);
    for (int k = 0; k < DEPTH; k++) begin
      nv[k] = m_v[k];
      nd[k] = m_d[k];
      if (rdy[k]) begin
        nv[k] = (k == 0) ? iv : m_v[k-1];
        nd[k] = (k == 0) ? id : m_d[k-1];
      end
      if (fl && rdy[k] && k == fs + 1) nv[k] = 1'b0;
      if (fl && k <= fs) nv[k] = 1'b0;
    end
    for (int k = 0; k < DEPTH; k++) begin
      m_v[k] = nv[k];
      m_d[k] = nd[k];
    end
    if (oxfer) m_ret = m_ret + 32'd1;
  endtask

  // One clock: check registered state, drive this cycle's inputs, advance the model.
  task automatic cycle(input bit iv, input logic [WIDTH-1:0] id, input bit ordy,
                       input bit fl, input int fsel, input bit rst);
    @(negedge clk);
    if (checking) begin
      check("occupancy", 32'(occupancy), 32'(m_occ()));
      check("out_valid", 32'(out_valid), 32'(m_v[DEPTH-1]));
      check("retired", retired, m_ret);
    end
    in_valid    = iv;
    in_data     = id;
    out_ready   = ordy;
    flush       = fl;
    flush_stage = SW'(fsel);
    reset       = rst;
    #1;
    if (checking) check("in_ready", 32'(in_ready), 32'(m_ready(0, ordy)));
    model_step(iv, id, ordy, fl, fsel, rst);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every accepted output, just before the edge.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (checking && !reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL scoreboard_underflow: got 0x%0h expected no output", out_data);
        end else begin
          check("out_data", out_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    flush = 1'b0; flush_stage = '0; reset = 1'b1;

    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    checking = 1'b1;

    // Streaming: three back-to-back payloads, latency DEPTH.
    cycle(1, 32'h11, 1, 0, 0, 0); settle();
    cycle(1, 32'h22, 1, 0, 0, 0); settle();
    cycle(1, 32'h33, 1, 0, 0, 0); settle();
    check("stream_not_yet_valid", 32'(out_valid), 32'd0);
    cycle(0, 0, 1, 0, 0, 0); settle();
    check("stream_first_valid", 32'(out_valid), 32'd1);
    check("stream_first_data", out_data, 32'h11);
    repeat (3) cycle(0, 0, 1, 0, 0, 0);
    settle();
    check("stream_retired", retired, 32'd3);

    // Backpressure: fill, stall, then release one.
    cycle(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cycle(1, 32'hA0 + 32'(i), 0, 0, 0, 0);
    settle();
    check("bp_in_ready_full", 32'(in_ready), 32'd0);
    check("bp_occupancy_full", 32'(occupancy), 32'd4);
    cycle(0, 0, 1, 0, 0, 0);
    check("bp_in_ready_release", 32'(in_ready), 32'd1);
    settle();
    check("bp_occupancy_after", 32'(occupancy), 32'd3);
    check("bp_retired", retired, 32'd1);
    repeat (4) cycle(0, 0, 1, 0, 0, 0);

    // Bubble collapse: oldest parked in the last stage, young payload slides up behind it.
    cycle(0, 0, 0, 0, 0, 1);
    cycle(1, 32'hC0, 0, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 32'hC1, 0, 0, 0, 0);
    settle();
    check("bubble_occ_start", 32'(occupancy), 32'd2);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    settle();
    check("bubble_occ_after", 32'(occupancy), 32'd2);
    check("bubble_head_holds", out_data, 32'hC0);
    check("bubble_in_ready", 32'(in_ready), 32'd1);
    cycle(1, 32'hC2, 0, 0, 0, 0); settle();
    check("bubble_occ_three", 32'(occupancy), 32'd3);
    repeat (5) cycle(0, 0, 1, 0, 0, 0);

    // Partial flush at stage 1 with a concurrent output and a dropped input.
    cycle(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cycle(1, 32'hB0 + 32'(i), 0, 0, 0, 0);
    cycle(1, 32'hB4, 1, 1, 1, 0);
    settle();
    check("pflush_occupancy", 32'(occupancy), 32'd1);
    check("pflush_out_valid", 32'(out_valid), 32'd1);
    check("pflush_out_data", out_data, 32'hB1);
    check("pflush_retired", retired, 32'd1);
    repeat (2) cycle(0, 0, 1, 0, 0, 0);

    // Full flush without reset: the concurrent output still counts.
    for (int i = 0; i < 4; i++) cycle(1, 32'hE0 + 32'(i), 0, 0, 0, 0);
    cycle(0, 0, 1, 1, DEPTH-1, 0);
    settle();
    check("fflush_occupancy", 32'(occupancy), 32'd0);
    check("fflush_retired", retired, 32'd3);

    // Full flush racing reset: reset wins.
    for (int i = 0; i < 3; i++) cycle(1, 32'hF0 + 32'(i), 0, 0, 0, 0);
    cycle(1, 32'hF9, 1, 1, DEPTH-1, 1);
    settle();
    check("race_occupancy", 32'(occupancy), 32'd0);
    check("race_retired", retired, 32'd0);
    check("race_in_ready", 32'(in_ready), 32'd1);

    // Counter wrap from a forced all-ones value.
    cycle(1, 32'hD0, 0, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 0, 0, 0);
    force dut.retired = 32'hFFFF_FFFF;
    #1;
    release dut.retired;
    m_ret = 32'hFFFF_FFFF;
    settle();
    check("wrap_preload", retired, 32'hFFFF_FFFF);
    cycle(0, 0, 1, 0, 0, 0);
    settle();
    check("wrap_zero", retired, 32'd0);

    // Random traffic with occasional flushes and resets.
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0, int'($urandom_range(0, (1 << SW) - 1)),
            $urandom_range(0, 299) == 0);
    end
    repeat (DEPTH + 4) cycle(0, 0, 1, 0, 0, 0);
    settle();
    check("drain_occupancy", 32'(occupancy), 32'd0);
    check("drain_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_chain.md
PIPELINE_CHAIN -- requirements
Module: pipeline_chain

Interface
REQ-001 Parameter: WIDTH, default 32, payload width in bits per stage.
REQ-002 Parameter: DEPTH, default 4, number of pipeline register stages (legal range 2..16).
REQ-003 Parameter: SW, default $clog2(DEPTH), width of flush_stage.
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: in_valid  input  1  upstream presents a payload.
REQ-007 Port: in_ready  output  1  chain accepts a payload this cycle.
REQ-008 Port: in_data  input  WIDTH  upstream payload.
REQ-009 Port: out_valid  output  1  stage DEPTH-1 holds a valid payload.
REQ-010 Port: out_ready  input  1  downstream consumes the payload this cycle.
REQ-011 Port: out_data  output  WIDTH  payload of stage DEPTH-1.
REQ-012 Port: flush  input  1  invalidate younger stages this cycle.
REQ-013 Port: flush_stage  input  SW  oldest stage index to invalidate; stage 0 is youngest.
REQ-014 Port: occupancy  output  $clog2(DEPTH+1)  count of valid stages.
REQ-015 Port: retired  output  32  count of completed output transfers, wraps modulo 2^32.

Function
REQ-016 The block SHALL hold a valid bit v[k] and payload d[k] per stage k = 0..DEPTH-1.
REQ-017 Stage readiness SHALL be r[k] = !v[k] || r[k+1], with r[DEPTH] = out_ready (combinational bubble collapse).
REQ-018 in_ready SHALL equal r[0]; in_ready SHALL NOT depend on in_valid.
REQ-019 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-020 When r[k] is high, stage k SHALL load v[k-1], d[k-1] (stage 0 loads in_valid, in_data); when r[k] is low, stage k SHALL hold.
REQ-021 out_valid = v[DEPTH-1] and out_data = d[DEPTH-1], both driven directly from registers.
REQ-022 Latency SHALL be exactly DEPTH cycles from input transfer to out_valid in an empty, unstalled chain; throughput is one payload per cycle.
REQ-023 Payload order SHALL be preserved; no payload is duplicated or dropped except by flush.
REQ-024 On flush, v[k] SHALL be cleared for all k <= min(flush_stage, DEPTH-1), and any input transfer in the same cycle SHALL be discarded.
REQ-025 On flush, stage flush_stage+1 SHALL NOT receive the payload leaving stage flush_stage; it loads invalid if r[flush_stage+1] is high, otherwise it holds.
REQ-026 Stages older than flush_stage+1 SHALL advance normally during flush.
REQ-027 flush_stage >= DEPTH-1 SHALL clear every stage; an output transfer occurring in that cycle SHALL still complete and count in retired.
REQ-028 occupancy SHALL equal the population count of v[], registered, and updated in the same edge as v[].
REQ-029 retired SHALL increment by 1 on each output transfer and wrap from 0xFFFFFFFF to 0.
REQ-030 Payload registers of invalid stages are don't-care; out_data SHALL be ignored while out_valid is low.

Reset
REQ-031 When reset is high at a rising edge, all v[k], occupancy, and retired SHALL become 0; payload registers are not reset.
REQ-032 reset SHALL take priority over flush and over any transfer in the same cycle; in_ready SHALL be 1 in the first cycle after reset.

Verification
REQ-033 Streaming: DEPTH=4, out_ready=1, inputs 0x11,0x22,0x33 on consecutive cycles from cycle 0 -> out_valid with 0x11,0x22,0x33 on cycles 4,5,6; retired=3.
REQ-034 Backpressure: fill with 0xA0..0xA3, out_ready=0 -> in_ready=0 and occupancy=4; raise out_ready for 1 cycle -> 0xA0 retires and in_ready=1 that cycle.
REQ-035 Bubble collapse: stages 0 and 3 valid, out_ready=0 -> stage 0 advances to stage 2 within 2 cycles, occupancy stays 2, and stage 3 holds.
REQ-036 Partial flush: full chain 0xB0..0xB3 (0xB0 oldest), flush=1, flush_stage=1, out_ready=1, in_valid=1 with 0xB4 -> 0xB0 retires; 0xB1 moves to stage 3; stages 0-2 invalid; 0xB4 dropped; occupancy=1.
REQ-037 Full flush with reset race: flush_stage=3 and reset=1 in the same cycle -> occupancy=0 and retired=0; next cycle in_ready=1.
REQ-038 Counter wrap: preload retired to 0xFFFFFFFF by forcing, then perform one output transfer -> retired=0.
